// File: rtl/four_bank_resp_pkg.sv
// Shared defaults and field positions for the four-bank
// interleaved memory with a fixed-latency read return.
package four_bank_resp_pkg;
  localparam int DEF_BANK_CYCLES = 4;
  localparam int DEF_READ_LAT = 2;
  localparam int DEF_IDX_W = 6;
  localparam int BANK_LO = 1;
  localparam int BANK_HI = 2;
  localparam int CNT_W = 2;
  localparam int DATA_W = 16;
endpackage

// File: rtl/four_bank_resp_mem_bank.sv
// One bank: word storage, occupancy counter and a single
// shared read/write port driven by the top-level decode.
module mem_bank
  import four_bank_resp_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int BANK_CYCLES = DEF_BANK_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(BANK_CYCLES - 1);

  logic [DATA_W-1:0] mem [2**IDX_W];
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < 2**IDX_W; i++) mem[i] <= '0;
    end else begin
      if (acc) cnt <= LOAD;
      else if (cnt != '0) cnt <= cnt - 1'b1;
      if (acc && we) mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];
  assign busy = (cnt != '0);
endmodule

// File: rtl/four_bank_resp.sv
// Request decode, err/stall arbitration and the read return
// pipeline in front of four interleaved banks.
module four_bank_resp
  import four_bank_resp_pkg::*;
#(
  parameter int BANK_CYCLES = DEF_BANK_CYCLES,
  parameter int READ_LAT = DEF_READ_LAT,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);
  logic [1:0]        bank;
  logic [IDX_W-1:0]  idx;
  logic              req;
  logic              acc;
  logic [DATA_W-1:0] rdata [4];
  logic [READ_LAT-1:0] vld;
  logic [DATA_W-1:0] pdat [READ_LAT];
  logic              unused_addr;

  assign bank = addr[BANK_HI:BANK_LO];
  assign idx = addr[IDX_W+2:3];
  assign unused_addr = ^addr[15:IDX_W+3];

  assign req = rd | wr;
  assign err = (rd & wr) | (req & addr[0]);
  assign stall = req & ~err & busy[bank];
  assign acc = req & ~err & ~stall;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    mem_bank #(
      .IDX_W(IDX_W),
      .BANK_CYCLES(BANK_CYCLES)
    ) u_bank (
      .clk(clk),
      .rst(rst),
      .acc(acc && (bank == 2'(b))),
      .we(wr),
      .idx(idx),
      .wdata(data_in),
      .rdata(rdata[b]),
      .busy(busy[b])
    );
  end

  // Stage 0 captures the word at the end of the accept cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < READ_LAT; i++) pdat[i] <= '0;
    end else begin
      vld[0] <= acc & rd;
      pdat[0] <= rdata[bank];
      for (int i = 1; i < READ_LAT; i++) begin
        vld[i] <= vld[i-1];
        pdat[i] <= pdat[i-1];
      end
    end
  end

  assign data_out = vld[READ_LAT-1] ? pdat[READ_LAT-1] : '0;
endmodule
